// File: rtl/bus_demux_1to4_pkg.sv
// Shared definitions for the 1:4 return-path demux and its 4:1 mux counterpart.
package bus_demux_1to4_pkg;

  localparam logic [1:0] DEST_OUT1 = 2'b00;
  localparam logic [1:0] DEST_OUT2 = 2'b01;
  localparam logic [1:0] DEST_OUT3 = 2'b10;
  localparam logic [1:0] DEST_OUT4 = 2'b11;

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic logic [3:0] dest_onehot(input logic [1:0] sel);
    logic [3:0] oh;
    oh = 4'b0000;
    case (sel)
      DEST_OUT1: oh = 4'b0001;
      DEST_OUT2: oh = 4'b0010;
      DEST_OUT3: oh = 4'b0100;
      DEST_OUT4: oh = 4'b1000;
      default:   oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bus_demux_fifo.sv
// Per-destination synchronous FIFO; head word is read straight from storage.
// Writes when full and reads when empty are ignored.
module bus_demux_fifo
  import bus_demux_1to4_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int DEPTH    = 2
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [BITWIDTH-1:0] WrData,
  input  logic                WrEn,
  input  logic                RdEn,
  output logic [BITWIDTH-1:0] RdData,
  output logic                Full,
  output logic                Empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("bus_demux_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [BITWIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                do_wr, do_rd;

  assign Full  = (count_q == CNT_W'(DEPTH));
  assign Empty = (count_q == '0);
  assign do_wr = WrEn & ~Full;
  assign do_rd = RdEn & ~Empty;

  // When empty, show the slot just behind rd_ptr: that is the last word
  // popped (or zero after reset), so the output holds its final value.
  assign RdData = Empty ? mem_q[rd_ptr_q - PTR_W'(1)] : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_wr) mem_q[wr_ptr_q] <= WrData;
    end
  end

endmodule

// File: rtl/bus_demux_1to4.sv
// Steers one read-data stream into four independent per-master FIFOs.
// A full destination only stalls words addressed to it.
module bus_demux_1to4
  import bus_demux_1to4_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int DEPTH    = 2
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [BITWIDTH-1:0] DataIn,
  input  logic [1:0]          InSel,
  input  logic                InValid,
  output logic                InReady,
  output logic [BITWIDTH-1:0] Out1,
  output logic [BITWIDTH-1:0] Out2,
  output logic [BITWIDTH-1:0] Out3,
  output logic [BITWIDTH-1:0] Out4,
  output logic [3:0]          OutValid,
  input  logic [3:0]          OutReady
);

  logic [3:0]          full_w;
  logic [3:0]          empty_w;
  logic [3:0]          wr_en;
  logic [3:0]          rd_en;
  logic [BITWIDTH-1:0] rd_dat [4];

  assign InReady  = ~full_w[InSel];
  assign wr_en    = dest_onehot(InSel) & {4{InValid & InReady}};
  assign OutValid = ~empty_w;
  assign rd_en    = OutValid & OutReady;

  for (genvar k = 0; k < 4; k++) begin : g_fifo
    bus_demux_fifo #(
      .BITWIDTH (BITWIDTH),
      .DEPTH    (DEPTH)
    ) u_fifo (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .WrData (DataIn),
      .WrEn   (wr_en[k]),
      .RdEn   (rd_en[k]),
      .RdData (rd_dat[k]),
      .Full   (full_w[k]),
      .Empty  (empty_w[k])
    );
  end

  assign Out1 = rd_dat[0];
  assign Out2 = rd_dat[1];
  assign Out3 = rd_dat[2];
  assign Out4 = rd_dat[3];

endmodule

// File: tb/tb_bus_demux_1to4.sv
module tb_bus_demux_1to4;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [7:0] DataIn;
  logic [1:0] InSel;
  logic       InValid;
  logic       InReady;
  logic [7:0] Out1, Out2, Out3, Out4;
  logic [3:0] OutValid;
  logic [3:0] OutReady;

  int total = 0;
  int bad   = 0;

  bus_demux_1to4 #(.BITWIDTH(8), .DEPTH(2)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .DataIn   (DataIn),
    .InSel    (InSel),
    .InValid  (InValid),
    .InReady  (InReady),
    .Out1     (Out1),
    .Out2     (Out2),
    .Out3     (Out3),
    .Out4     (Out4),
    .OutValid (OutValid),
    .OutReady (OutReady)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] sel, input logic [7:0] d);
    InValid = 1'b1;
    InSel   = sel;
    DataIn  = d;
  endtask

  initial begin
    // 1. reset held with InValid high
    Rst_n = 1'b0; InValid = 1'b1; InSel = 2'd0; DataIn = 8'h55; OutReady = 4'b0000;
    tick(); tick();
    check("rst_outvalid", 8'(OutValid), 8'h00);
    check("rst_out1", Out1, 8'h00);
    check("rst_out2", Out2, 8'h00);
    check("rst_out3", Out3, 8'h00);
    check("rst_out4", Out4, 8'h00);
    check("rst_inready", 8'(InReady), 8'h01);
    Rst_n = 1'b1;
    push(2'd0, 8'h5A);
    tick();
    check("first_push_vld", 8'(OutValid), 8'h01);
    check("first_push_dat", Out1, 8'h5A);
    InValid = 1'b0; OutReady = 4'b0001;
    tick();
    check("first_pop_vld", 8'(OutValid), 8'h00);
    check("empty_holds_last", Out1, 8'h5A);

    // 2. routing
    OutReady = 4'b0000;
    push(2'd0, 8'hA1); tick(); check("route_out1", Out1, 8'hA1);
    push(2'd1, 8'hA2); tick(); check("route_out2", Out2, 8'hA2);
    push(2'd2, 8'hA3); tick(); check("route_out3", Out3, 8'hA3);
    push(2'd3, 8'hA4); tick(); check("route_out4", Out4, 8'hA4);
    check("route_vld", 8'(OutValid), 8'h0F);
    InValid = 1'b0; OutReady = 4'b1111;
    tick();
    check("drain_all", 8'(OutValid), 8'h00);

    // 3. full / backpressure on Out3
    OutReady = 4'b0000;
    push(2'd2, 8'h10); #1 check("bp_rdy0", 8'(InReady), 8'h01); tick();
    push(2'd2, 8'h11); #1 check("bp_rdy1", 8'(InReady), 8'h01); tick();
    push(2'd2, 8'h12); #1 check("bp_full_rdy", 8'(InReady), 8'h00);
    InSel = 2'd0; #1 check("bp_other0", 8'(InReady), 8'h01);
    InSel = 2'd1; #1 check("bp_other1", 8'(InReady), 8'h01);
    InSel = 2'd3; #1 check("bp_other3", 8'(InReady), 8'h01);
    InSel = 2'd2; OutReady = 4'b0100;
    tick();
    check("bp_pop_out3", Out3, 8'h11);
    check("bp_pop_vld", 8'(OutValid), 8'h04);
    OutReady = 4'b0000; #1 check("bp_rdy_again", 8'(InReady), 8'h01);
    tick();
    check("bp_head_kept", Out3, 8'h11);
    InValid = 1'b0; OutReady = 4'b0100;
    tick(); check("bp_third", Out3, 8'h12);
    tick(); check("bp_drained", 8'(OutValid), 8'h00);

    // 4. streaming wrap-around on Out1
    OutReady = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      push(2'd0, 8'(i));
      tick();
      check("stream_dat", Out1, 8'(i));
      check("stream_vld", 8'(OutValid), 8'h01);
    end
    InValid = 1'b0;
    tick();
    check("stream_end_vld", 8'(OutValid), 8'h00);
    check("stream_end_hold", Out1, 8'h09);

    // 5. simultaneous push/pop while full
    OutReady = 4'b0000;
    push(2'd0, 8'hB0); tick();
    push(2'd0, 8'hB1); tick();
    push(2'd0, 8'hB2); OutReady = 4'b0001;
    #1 check("pp_full_rdy", 8'(InReady), 8'h00);
    tick();
    check("pp_popped", Out1, 8'hB1);
    check("pp_vld", 8'(OutValid), 8'h01);
    OutReady = 4'b0000; #1 check("pp_rdy_next", 8'(InReady), 8'h01);
    tick();
    InValid = 1'b0; OutReady = 4'b0001;
    tick(); check("pp_b2", Out1, 8'hB2);
    tick(); check("pp_empty", 8'(OutValid), 8'h00);

    // 6. reset mid-stream
    OutReady = 4'b0000;
    push(2'd1, 8'hC1); tick();
    push(2'd1, 8'hC2); tick();
    InValid = 1'b0;
    check("mid_pre_out2", Out2, 8'hC1);
    check("mid_pre_rdy", 8'(InReady), 8'h00);
    Rst_n = 1'b0;
    #1;
    check("mid_async_vld", 8'(OutValid), 8'h00);
    check("mid_async_out2", Out2, 8'h00);
    tick();
    Rst_n = 1'b1;
    tick();
    check("mid_post_vld", 8'(OutValid), 8'h00);
    push(2'd1, 8'hD1); tick();
    check("mid_new_out2", Out2, 8'hD1);
    InValid = 1'b0; OutReady = 4'b0010;
    tick();
    check("mid_no_stale", 8'(OutValid), 8'h00);
    check("mid_hold", Out2, 8'hD1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
